// File: rtl/id_ex_skid_reg.sv
// id_ex_skid_reg: ID->EX pipeline boundary with a 2-entry skid buffer.
// Main register drives the *_ex outputs, and a skid register absorbs one extra entry during an EX stall.
// Handshake: a transfer happens on a side only in a cycle where valid and ready are both high at the
// rising edge (acc = in_valid & in_ready, pop = out_valid & out_ready).
// ready never depends combinationally on valid on the same side.
// Optional feature: define ALUCODE_CHECK_EN to replace unsupported ALU codes with ADD and raise illegal_ex.
module id_ex_skid_reg #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ALUCode_id,
  input  logic [XLEN-1:0] A_id,
  input  logic [XLEN-1:0] B_id,
  input  logic [RD_W-1:0] rd_id,
  input  logic            RegWrite_id,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      ALUCode_ex,
  output logic [XLEN-1:0] A_ex,
  output logic [XLEN-1:0] B_ex,
  output logic [RD_W-1:0] rd_ex,
  output logic            RegWrite_ex,
  output logic            illegal_ex,
  output logic [1:0]      state_dbg
);

  // Encoding chosen so that bit0 is the main valid bit and bit1 is the skid valid bit.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  typedef struct packed {
    logic [3:0]      alucode;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RD_W-1:0] rd;
    logic            regwrite;
`ifdef ALUCODE_CHECK_EN
    logic            illegal;
`endif
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, in_entry;
  logic   acc, pop;
  logic   load_main_in, load_main_skid, load_skid_in;
  logic   m_v, s_v;

  assign m_v       = state_q[0];
  assign s_v       = state_q[1];
  assign in_ready  = ~s_v;
  assign out_valid = m_v;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign state_dbg = state_q;

  // Build the entry to capture from the ID-side inputs, sanitising the ALU code if enabled.
  always_comb begin
    in_entry.alucode  = ALUCode_id;
    in_entry.a        = A_id;
    in_entry.b        = B_id;
    in_entry.rd       = rd_id;
    in_entry.regwrite = RegWrite_id;
`ifdef ALUCODE_CHECK_EN
    in_entry.illegal  = 1'b0;
    if ((ALUCode_id == 4'd2) || (ALUCode_id > 4'd10)) begin
      in_entry.alucode  = 4'd0;
      in_entry.regwrite = 1'b0;
      in_entry.illegal  = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next state and data-register load enables. Flush overrides every transfer.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (acc && pop) begin
            load_main_in = 1'b1;
          end else if (acc) begin
            load_skid_in = 1'b1;
            state_d      = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // No acceptance here even on pop, so in_ready stays a pure flop output.
          if (pop) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Main data register: loads from the input or from the skid; flush leaves contents alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               main_q <= '0;
    else if (load_main_in)   main_q <= in_entry;
    else if (load_main_skid) main_q <= skid_q;
  end

  // Skid data register: loads only when ONE accepts without a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             skid_q <= '0;
    else if (load_skid_in) skid_q <= in_entry;
  end

  assign ALUCode_ex  = main_q.alucode;
  assign A_ex        = main_q.a;
  assign B_ex        = main_q.b;
  assign rd_ex       = main_q.rd;
  assign RegWrite_ex = main_q.regwrite & m_v;
`ifdef ALUCODE_CHECK_EN
  assign illegal_ex  = main_q.illegal & m_v;
`else
  assign illegal_ex  = 1'b0;
`endif

endmodule
